// File: rtl/ct_pmp_pkg.sv
// ct_pmp_pkg
//   Shared definitions for the PMP check pipe: access-type encodings,
//   positions of the lookup flag bits, and default bus widths.
package ct_pmp_pkg;

  localparam int PMP_PA_WIDTH = 28;
  localparam int PMP_ID_WIDTH = 4;

  localparam logic [1:0] PMP_ACC_RD  = 2'b00;
  localparam logic [1:0] PMP_ACC_WR  = 2'b01;
  localparam logic [1:0] PMP_ACC_EX  = 2'b10;
  localparam logic [1:0] PMP_ACC_RSV = 2'b11;

  // Bit positions inside the {L,X,W,R} flag nibble.
  localparam int PMP_FLG_R = 0;
  localparam int PMP_FLG_W = 1;
  localparam int PMP_FLG_X = 2;
  localparam int PMP_FLG_L = 3;

endpackage

// File: rtl/ct_pmp_chk_fault.sv
// ct_pmp_chk_fault
//   Combinational access check: turns an access type and the {L,X,W,R}
//   flags returned by the lookup into a single fault bit.
// Ports
//   acc_type  in  2  access type (read / write / exec / reserved)
//   flg       in  4  {L,X,W,R} lookup flags
//   fault     out 1  access denied
module ct_pmp_chk_fault
  import ct_pmp_pkg::*;
(
  input  logic [1:0] acc_type,
  input  logic [3:0] flg,
  output logic       fault
);

  // L only locks the entry; the lookup has already folded it into R/W/X,
  // so it does not take part in the decision here.
  always_comb begin
    fault = ((acc_type == PMP_ACC_RD) & ~flg[PMP_FLG_R])
          | ((acc_type == PMP_ACC_WR) & ~flg[PMP_FLG_W])
          | ((acc_type == PMP_ACC_EX) & ~flg[PMP_FLG_X])
          |  (acc_type == PMP_ACC_RSV);
  end

endmodule

// File: rtl/ct_pmp_chk_pipe.sv
// ct_pmp_chk_pipe
//   Two-stage pipe around the PMP flag lookup. S1 arbitrates PTW/JTLB
//   requests and registers the PA and MPRV qualifier that drive the lookup;
//   S2 captures the returned flags, derives the fault and presents the
//   response to the requester.
// Ports
//   forever_cpuclk / cpurst_b          clock, async active-low reset
//   ptw_pmp_req_* / pmp_ptw_req_rdy    PTW request channel (high priority)
//   jtlb_pmp_req_* / pmp_jtlb_req_rdy  JTLB request channel
//   mmu_pmp_flush                      kill everything in flight
//   mmu_pmp_pa_y, pmp_mprv_status_y    S1 registers to the lookup
//   pmp_mmu_flg_y                      lookup flags, combinational from S1
//   pmp_resp_*                         response channel
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Request ready is computed from pipe occupancy only and never
// looks at the requester's own valid. The response side holds all
// pmp_resp_* stable while pmp_resp_vld is high and pmp_resp_rdy is low.
module ct_pmp_chk_pipe
  import ct_pmp_pkg::*;
#(
  parameter int PA_WIDTH = PMP_PA_WIDTH,
  parameter int ID_WIDTH = PMP_ID_WIDTH
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                ptw_pmp_req_vld,
  input  logic [PA_WIDTH-1:0] ptw_pmp_req_pa,
  input  logic [ID_WIDTH-1:0] ptw_pmp_req_id,
  output logic                pmp_ptw_req_rdy,
  input  logic                jtlb_pmp_req_vld,
  input  logic [PA_WIDTH-1:0] jtlb_pmp_req_pa,
  input  logic [ID_WIDTH-1:0] jtlb_pmp_req_id,
  input  logic [1:0]          jtlb_pmp_req_type,
  input  logic                jtlb_pmp_req_mprv,
  output logic                pmp_jtlb_req_rdy,
  input  logic                mmu_pmp_flush,
  output logic [PA_WIDTH-1:0] mmu_pmp_pa_y,
  output logic                pmp_mprv_status_y,
  input  logic [3:0]          pmp_mmu_flg_y,
  output logic                pmp_resp_vld,
  input  logic                pmp_resp_rdy,
  output logic                pmp_resp_src,
  output logic [ID_WIDTH-1:0] pmp_resp_id,
  output logic [3:0]          pmp_resp_flg,
  output logic                pmp_resp_fault
);

  logic                s1_vld;
  logic                s1_src;
  logic [ID_WIDTH-1:0] s1_id;
  logic [1:0]          s1_type;

  logic                s2_adv;
  logic                s1_acc;
  logic                req_any;
  logic [PA_WIDTH-1:0] req_pa;
  logic [ID_WIDTH-1:0] req_id;
  logic [1:0]          req_type;
  logic                req_mprv;
  logic                s1_fault;

  // pmp_resp_vld is the S2 valid bit itself.
  assign s2_adv = s1_vld & (~pmp_resp_vld | pmp_resp_rdy);
  assign s1_acc = ~mmu_pmp_flush & (~s1_vld | s2_adv);

  assign pmp_ptw_req_rdy  = s1_acc;
  assign pmp_jtlb_req_rdy = s1_acc & ~ptw_pmp_req_vld;

  assign req_any = ptw_pmp_req_vld | jtlb_pmp_req_vld;

  // Fixed priority mux. PTW walks are always reads without MPRV; MPRV never
  // applies to instruction fetch.
  always_comb begin
    req_pa   = jtlb_pmp_req_pa;
    req_id   = jtlb_pmp_req_id;
    req_type = jtlb_pmp_req_type;
    req_mprv = jtlb_pmp_req_mprv & (jtlb_pmp_req_type != PMP_ACC_EX);
    if (ptw_pmp_req_vld) begin
      req_pa   = ptw_pmp_req_pa;
      req_id   = ptw_pmp_req_id;
      req_type = PMP_ACC_RD;
      req_mprv = 1'b0;
    end
  end

  // S1: the PA/MPRV registers double as the lookup drive and only change on
  // a real capture, so the lookup input is stable across stalls.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_vld            <= 1'b0;
      s1_src            <= 1'b0;
      s1_id             <= '0;
      s1_type           <= PMP_ACC_RD;
      mmu_pmp_pa_y      <= '0;
      pmp_mprv_status_y <= 1'b0;
    end else if (mmu_pmp_flush) begin
      s1_vld <= 1'b0;
    end else if (s1_acc) begin
      s1_vld <= req_any;
      if (req_any) begin
        s1_src            <= ptw_pmp_req_vld;
        s1_id             <= req_id;
        s1_type           <= req_type;
        mmu_pmp_pa_y      <= req_pa;
        pmp_mprv_status_y <= req_mprv;
      end
    end
  end

  ct_pmp_chk_fault u_fault (
    .acc_type (s1_type),
    .flg      (pmp_mmu_flg_y),
    .fault    (s1_fault)
  );

  // S2: flush drops a pending response even if it would have handed off
  // this cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pmp_resp_vld   <= 1'b0;
      pmp_resp_src   <= 1'b0;
      pmp_resp_id    <= '0;
      pmp_resp_flg   <= '0;
      pmp_resp_fault <= 1'b0;
    end else if (mmu_pmp_flush) begin
      pmp_resp_vld <= 1'b0;
    end else if (s2_adv) begin
      pmp_resp_vld   <= 1'b1;
      pmp_resp_src   <= s1_src;
      pmp_resp_id    <= s1_id;
      pmp_resp_flg   <= pmp_mmu_flg_y;
      pmp_resp_fault <= s1_fault;
    end else if (pmp_resp_rdy) begin
      pmp_resp_vld <= 1'b0;
    end
  end

endmodule
